// File: rtl/mac_sched_pkg.sv
// Shared types, default tile geometry and width helper for the MAC sequencer.
package mac_sched_pkg;

    function automatic int unsigned cw(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_IMG_W  = 4;
    localparam int unsigned DEF_IMG_H  = 4;
    localparam int unsigned DEF_N_OCH  = 16;
    localparam int unsigned DEF_N_GRP  = 3;
    localparam int unsigned DEF_RD_LAT = 1;
    localparam int unsigned DEF_ACC_W  = 21;
    localparam int unsigned DEF_PSUM_W = 32;

    localparam int unsigned N_PIX     = DEF_IMG_W * DEF_IMG_H;
    localparam int unsigned TOTAL_OPS = N_PIX * DEF_N_OCH * DEF_N_GRP;
    localparam int unsigned W_ADDR_W  = cw(DEF_N_OCH * DEF_N_GRP);
    localparam int unsigned D_ADDR_W  = cw(N_PIX * DEF_N_GRP);
    localparam int unsigned PIX_W     = cw(N_PIX);
    localparam int unsigned OCH_W     = cw(DEF_N_OCH);

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_ISSUE = 2'd1;
    localparam state_t S_DRAIN = 2'd2;
    localparam state_t S_DONE  = 2'd3;

endpackage

// File: rtl/mac_sched_vld_delay.sv
// Fixed-depth valid delay line turning the buffer read strobe into the MAC valid.
module vld_delay #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= DEPTH'({sr_q, d_i});
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/mac_sched.sv
// Tile sequencer for one MAC datapath: issues reads pixel->och->group, sums group results.
// Build option MAC_SCHED_RELU_EN clamps negative results to zero.
module mac_sched
    import mac_sched_pkg::*;
#(
    parameter int unsigned IMG_W  = DEF_IMG_W,
    parameter int unsigned IMG_H  = DEF_IMG_H,
    parameter int unsigned N_OCH  = DEF_N_OCH,
    parameter int unsigned N_GRP  = DEF_N_GRP,
    parameter int unsigned RD_LAT = DEF_RD_LAT,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned PSUM_W = DEF_PSUM_W
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 start_i,
    input  logic                                 in_stall_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 rd_en_o,
    output logic [cw(N_OCH*N_GRP)-1:0]           w_addr_o,
    output logic [cw(IMG_W*IMG_H*N_GRP)-1:0]     d_addr_o,
    output logic                                 mac_vld_o,
    input  logic [ACC_W-1:0]                     mac_acc_i,
    input  logic                                 mac_acc_vld_i,
    output logic                                 out_vld_o,
    output logic [PSUM_W-1:0]                    out_data_o,
    output logic [cw(IMG_W*IMG_H)-1:0]           out_pix_o,
    output logic [cw(N_OCH)-1:0]                 out_och_o
);
    localparam int unsigned T_PIX = IMG_W * IMG_H;
    localparam int unsigned T_OPS = T_PIX * N_OCH * N_GRP;
    localparam int unsigned WAW   = cw(N_OCH * N_GRP);
    localparam int unsigned DAW   = cw(T_PIX * N_GRP);
    localparam int unsigned PW    = cw(T_PIX);
    localparam int unsigned OW    = cw(N_OCH);
    localparam int unsigned GW    = cw(N_GRP);
    localparam int unsigned CW    = cw(T_OPS + 1);

    state_t            state_q, state_d;
    logic [GW-1:0]     grp_q, grp_d, ret_grp_q, ret_grp_d;
    logic [OW-1:0]     och_q, och_d, ret_och_q, ret_och_d;
    logic [PW-1:0]     pix_q, pix_d, ret_pix_q, ret_pix_d;
    logic [CW-1:0]     ret_cnt_q, ret_cnt_d;
    logic [PSUM_W-1:0] psum_q, psum_d, acc_ext;
    logic              busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d, out_vld_q, out_vld_d;
    logic [WAW-1:0]    w_addr_q, w_addr_d;
    logic [DAW-1:0]    d_addr_q, d_addr_d;
    logic [PSUM_W-1:0] out_data_q, out_data_d;
    logic [PW-1:0]     out_pix_q, out_pix_d;
    logic [OW-1:0]     out_och_q, out_och_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            grp_q      <= '0;
            och_q      <= '0;
            pix_q      <= '0;
            ret_grp_q  <= '0;
            ret_och_q  <= '0;
            ret_pix_q  <= '0;
            ret_cnt_q  <= '0;
            psum_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            w_addr_q   <= '0;
            d_addr_q   <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_pix_q  <= '0;
            out_och_q  <= '0;
        end else begin
            state_q    <= state_d;
            grp_q      <= grp_d;
            och_q      <= och_d;
            pix_q      <= pix_d;
            ret_grp_q  <= ret_grp_d;
            ret_och_q  <= ret_och_d;
            ret_pix_q  <= ret_pix_d;
            ret_cnt_q  <= ret_cnt_d;
            psum_q     <= psum_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            w_addr_q   <= w_addr_d;
            d_addr_q   <= d_addr_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_pix_q  <= out_pix_d;
            out_och_q  <= out_och_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grp_d      = grp_q;
        och_d      = och_q;
        pix_d      = pix_q;
        ret_grp_d  = ret_grp_q;
        ret_och_d  = ret_och_q;
        ret_pix_d  = ret_pix_q;
        ret_cnt_d  = ret_cnt_q;
        psum_d     = psum_q;
        rd_en_d    = 1'b0;
        w_addr_d   = w_addr_q;
        d_addr_d   = d_addr_q;
        out_vld_d  = 1'b0;
        out_data_d = out_data_q;
        out_pix_d  = out_pix_q;
        out_och_d  = out_och_q;
        acc_ext    = PSUM_W'($signed(mac_acc_i));

        case (state_q)
            S_IDLE: begin
                grp_d     = '0;
                och_d     = '0;
                pix_d     = '0;
                ret_grp_d = '0;
                ret_och_d = '0;
                ret_pix_d = '0;
                ret_cnt_d = '0;
                if (start_i) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (!in_stall_i) begin
                    rd_en_d  = 1'b1;
                    w_addr_d = WAW'(32'(och_q) * N_GRP + 32'(grp_q));
                    d_addr_d = DAW'(32'(pix_q) * N_GRP + 32'(grp_q));
                    if (grp_q == GW'(N_GRP - 1)) begin
                        grp_d = '0;
                        if (och_q == OW'(N_OCH - 1)) begin
                            och_d = '0;
                            if (pix_q == PW'(T_PIX - 1)) begin
                                pix_d   = '0;
                                state_d = S_DRAIN;
                            end else begin
                                pix_d = pix_q + PW'(1);
                            end
                        end else begin
                            och_d = och_q + OW'(1);
                        end
                    end else begin
                        grp_d = grp_q + GW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (ret_cnt_q == CW'(T_OPS)) state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Results only count while a tile is in flight; stragglers after reset are dropped.
        if (mac_acc_vld_i && (state_q == S_ISSUE || state_q == S_DRAIN)) begin
            psum_d    = (ret_grp_q == '0) ? acc_ext : psum_q + acc_ext;
            ret_cnt_d = ret_cnt_q + CW'(1);
            if (ret_grp_q == GW'(N_GRP - 1)) begin
                ret_grp_d = '0;
                out_vld_d = 1'b1;
                out_pix_d = ret_pix_q;
                out_och_d = ret_och_q;
`ifdef MAC_SCHED_RELU_EN
                out_data_d = psum_d[PSUM_W-1] ? '0 : psum_d;
`else
                out_data_d = psum_d;
`endif
                if (ret_och_q == OW'(N_OCH - 1)) begin
                    ret_och_d = '0;
                    ret_pix_d = (ret_pix_q == PW'(T_PIX - 1)) ? '0 : ret_pix_q + PW'(1);
                end else begin
                    ret_och_d = ret_och_q + OW'(1);
                end
            end else begin
                ret_grp_d = ret_grp_q + GW'(1);
            end
        end

        busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    vld_delay #(.DEPTH(RD_LAT)) u_vld_delay (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rd_en_q),
        .q_o   (mac_vld_o)
    );

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign rd_en_o    = rd_en_q;
    assign w_addr_o   = w_addr_q;
    assign d_addr_o   = d_addr_q;
    assign out_vld_o  = out_vld_q;
    assign out_data_o = out_data_q;
    assign out_pix_o  = out_pix_q;
    assign out_och_o  = out_och_q;

endmodule

// File: tb/tb_mac_sched.sv
// Self-checking bench for mac_sched on a 2x1 tile, 2 output channels, 3 groups.
module tb_mac_sched;
    localparam int unsigned IMG_W  = 2;
    localparam int unsigned IMG_H  = 1;
    localparam int unsigned N_OCH  = 2;
    localparam int unsigned N_GRP  = 3;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned ACC_W  = 21;
    localparam int unsigned PSUM_W = 32;
    localparam int N_OUT   = IMG_W * IMG_H * N_OCH;
    localparam int N_OPS   = N_OUT * N_GRP;
    localparam int MAC_LAT = 6;

    logic clk = 1'b0;
    logic rst_i = 1'b1, start_i = 1'b0, in_stall_i = 1'b0;
    logic busy_o, done_o, rd_en_o, mac_vld_o, out_vld_o;
    logic [2:0] w_addr_o, d_addr_o;
    logic [ACC_W-1:0] mac_acc_i = '0;
    logic mac_acc_vld_i = 1'b0;
    logic [PSUM_W-1:0] out_data_o;
    logic [0:0] out_pix_o, out_och_o;

    mac_sched #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .N_OCH(N_OCH), .N_GRP(N_GRP),
        .RD_LAT(RD_LAT), .ACC_W(ACC_W), .PSUM_W(PSUM_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .in_stall_i(in_stall_i),
        .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o),
        .w_addr_o(w_addr_o), .d_addr_o(d_addr_o), .mac_vld_o(mac_vld_o),
        .mac_acc_i(mac_acc_i), .mac_acc_vld_i(mac_acc_vld_i),
        .out_vld_o(out_vld_o), .out_data_o(out_data_o),
        .out_pix_o(out_pix_o), .out_och_o(out_och_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACC_W-1:0] due_v;
        int               due;
    } ret_t;

    typedef struct {
        string             name;
        logic [ACC_W-1:0]  v0, v1, v2;
        logic [PSUM_W-1:0] exp;
    } vec_t;

    int checks = 0, errors = 0;
    int cyc = 0, issued, mv_idx, outs, dones, last_out_cyc;
    int stall_lo = -1, stall_hi = -1, restart_at = -1;
    bit stall_prev = 1'b0;
    logic [ACC_W-1:0]  opval [N_OPS];
    logic [PSUM_W-1:0] exp_out [N_OUT];
    ret_t rq[$];
    vec_t vecs[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: each output is the wrapped sum of its group results, pixel-major then och.
    task automatic build_expected();
        for (int o = 0; o < N_OUT; o++) begin
            int s = 0;
            for (int g = 0; g < N_GRP; g++) s += int'($signed(opval[o*N_GRP+g]));
`ifdef MAC_SCHED_RELU_EN
            if (s < 0) s = 0;
`endif
            exp_out[o] = PSUM_W'(s);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (stall_prev) check("rd_en_during_stall", 64'(rd_en_o), 64'd0);
        if (rd_en_o) begin
            if (issued < N_OPS) begin
                int g = issued % N_GRP;
                int oc = (issued / N_GRP) % N_OCH;
                int px = issued / (N_GRP * N_OCH);
                check("w_addr", 64'(w_addr_o), 64'(oc * N_GRP + g));
                check("d_addr", 64'(d_addr_o), 64'(px * N_GRP + g));
            end else begin
                check("extra_issue", 64'(issued), 64'(N_OPS - 1));
            end
            issued++;
        end
        if (mac_vld_o) begin
            if (mv_idx < N_OPS) rq.push_back('{opval[mv_idx], cyc + MAC_LAT});
            mv_idx++;
        end
        if (out_vld_o) begin
            if (outs < N_OUT) begin
                check("out_data", 64'(out_data_o), 64'(exp_out[outs]));
                check("out_pix", 64'(out_pix_o), 64'(outs / N_OCH));
                check("out_och", 64'(out_och_o), 64'(outs % N_OCH));
            end
            outs++;
            last_out_cyc = cyc;
        end
        if (done_o) begin
            dones++;
            check("done_after_last_out", 64'(cyc), 64'(last_out_cyc + 1));
            check("busy_at_done", 64'(busy_o), 64'd0);
        end
        start_i    = (cyc == restart_at);
        in_stall_i = (cyc >= stall_lo) && (cyc < stall_hi);
        stall_prev = in_stall_i;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            mac_acc_vld_i = 1'b1;
            mac_acc_i     = rq[0].due_v;
            void'(rq.pop_front());
        end else begin
            mac_acc_vld_i = 1'b0;
            mac_acc_i     = ACC_W'($urandom);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({busy_o, done_o, rd_en_o, mac_vld_o, out_vld_o, w_addr_o, d_addr_o,
                         out_data_o, out_pix_o, out_och_o}), 64'd0);
    endtask

    task automatic run_tile(input int stall_rel, input int restart_rel);
        int t0;
        issued = 0; mv_idx = 0; outs = 0; dones = 0; last_out_cyc = -100;
        stall_lo   = (stall_rel < 0) ? -1 : cyc + stall_rel;
        stall_hi   = (stall_rel < 0) ? -1 : cyc + stall_rel + 5;
        restart_at = (restart_rel < 0) ? -1 : cyc + restart_rel;
        start_i = 1'b1;
        t0 = cyc;
        tick();
        check("busy_after_start", 64'(busy_o), 64'd1);
        while (dones == 0 && cyc < t0 + 300) tick();
        if (dones == 0) check("done_timeout", 64'd0, 64'd1);
        repeat (4) tick();
        check("ops_issued", 64'(issued), 64'(N_OPS));
        check("outputs", 64'(outs), 64'(N_OUT));
        check("done_count", 64'(dones), 64'd1);
        check("busy_idle", 64'(busy_o), 64'd0);
        stall_lo = -1; stall_hi = -1; restart_at = -1;
    endtask

    task automatic load_vec(input int i);
        for (int k = 0; k < N_OPS; k++)
            opval[k] = (k % N_GRP == 0) ? vecs[i].v0 : (k % N_GRP == 1) ? vecs[i].v1 : vecs[i].v2;
        for (int o = 0; o < N_OUT; o++) exp_out[o] = vecs[i].exp;
    endtask

    initial begin
        int snap_i, snap_o, snap_d, t0;

        vecs[0] = '{"basic", 21'd100, 21'(-50), 21'd7, 32'd57};
`ifdef MAC_SCHED_RELU_EN
        vecs[1] = '{"relu", 21'(-5), 21'(-3), 21'(-1), 32'd0};
        vecs[2] = '{"sign_ext", 21'h100000, 21'd0, 21'd0, 32'd0};
`else
        vecs[1] = '{"relu", 21'(-5), 21'(-3), 21'(-1), 32'hFFFF_FFF7};
        vecs[2] = '{"sign_ext", 21'h100000, 21'd0, 21'd0, 32'hFFF0_0000};
`endif

        repeat (2) tick();
        rst_i = 1'b0;
        tick();
        check_all_zero("reset_outputs");

        for (int i = 0; i < 3; i++) begin
            load_vec(i);
            run_tile(-1, -1);
        end

        load_vec(0);
        run_tile(3, -1);

        load_vec(0);
        run_tile(-1, 5);

        // Reset in the middle of a tile while results are still coming back.
        load_vec(0);
        issued = 0; mv_idx = 0; outs = 0; dones = 0; last_out_cyc = -100;
        start_i = 1'b1;
        t0 = cyc;
        while (issued < 5 && cyc < t0 + 50) tick();
        check("mid_reset_reached_5_issues", 64'(issued), 64'd5);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_all_zero("mid_reset_outputs");
        snap_i = issued; snap_o = outs; snap_d = dones;
        repeat (20) tick();
        check("no_issue_after_reset", 64'(issued), 64'(snap_i));
        check("no_out_after_reset", 64'(outs), 64'(snap_o));
        check("no_done_after_reset", 64'(dones), 64'(snap_d));
        rq.delete();
        load_vec(0);
        run_tile(-1, -1);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N_OPS; k++) opval[k] = ACC_W'($urandom);
            build_expected();
            run_tile((r % 2 == 0) ? -1 : int'($urandom_range(2, 8)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
